// File: rtl/seq_divider_16by4_if.sv
// Start/result bundle between a requester and seq_divider_16by4.
interface seq_divider_16by4_if;
    logic        start;
    logic [15:0] C;
    logic [3:0]  B;
    logic        busy;
    logic        done;
    logic [8:0]  Q;
    logic [3:0]  R;
    logic        ovf;
    logic        dz;

    modport master (
        output start, C, B,
        input  busy, done, Q, R, ovf, dz
    );

    modport slave (
        input  start, C, B,
        output busy, done, Q, R, ovf, dz
    );
endinterface

// File: rtl/seq_divider_16by4.sv
// Iterative restoring divider: 16-bit dividend by 4-bit divisor, one quotient bit per clock.
// Optional build macro DIV_SAT_EN saturates Q to 9'h1FF on quotient overflow.
module seq_divider_16by4 (
    input  logic                 clk,
    input  logic                 rst_n,
    seq_divider_16by4_if.slave   bus
);
    localparam int unsigned CW = 16;
    localparam int unsigned BW = 4;
    localparam int unsigned QW = 9;
    localparam int unsigned RW = 4;
    localparam int unsigned PW = BW + 1;
    localparam int unsigned NW = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [NW-1:0]   cnt_q,   cnt_d;
    logic [CW-1:0]   c_q,     c_d;
    logic [BW-1:0]   b_q,     b_d;
    logic [CW-1:0]   quot_q,  quot_d;
    logic [PW-1:0]   rem_q,   rem_d;
    logic            busy_q,  busy_d;
    logic            done_q,  done_d;
    logic [QW-1:0]   q_q,     q_d;
    logic [RW-1:0]   r_q,     r_d;
    logic            ovf_q,   ovf_d;
    logic            dz_q,    dz_d;

    logic [PW-1:0]   rem_trial;
    logic [PW-1:0]   rem_next;
    logic [CW-1:0]   quot_next;
    logic            fits;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= NW'(15);
            c_q     <= '0;
            b_q     <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
            ovf_q   <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            b_q     <= b_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            q_q     <= q_d;
            r_q     <= r_d;
            ovf_q   <= ovf_d;
            dz_q    <= dz_d;
        end
    end

    // Next-state, iteration step and result capture
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        b_d     = b_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        q_d     = q_q;
        r_d     = r_q;
        ovf_d   = ovf_q;
        dz_d    = dz_q;

        // rem_q stays below B, so the shifted trial value always fits in 5 bits
        rem_trial = {rem_q[RW-1:0], c_q[CW-1]};
        fits      = (rem_trial >= {1'b0, b_q});
        rem_next  = fits ? (rem_trial - {1'b0, b_q}) : rem_trial;
        quot_next = {quot_q[CW-2:0], fits};

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    c_d    = bus.C;
                    b_d    = bus.B;
                    quot_d = '0;
                    rem_d  = '0;
                    cnt_d  = NW'(15);
                    if (bus.B != '0) begin
                        state_d = S_CALC;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        q_d     = QW'(9'h1FF);
                        r_d     = '0;
                        ovf_d   = 1'b0;
                        dz_d    = 1'b1;
                    end
                end
            end
            S_CALC: begin
                c_d    = {c_q[CW-2:0], 1'b0};
                quot_d = quot_next;
                rem_d  = rem_next;
                cnt_d  = cnt_q - NW'(1);
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    r_d     = rem_next[RW-1:0];
                    ovf_d   = |quot_next[CW-1:QW];
                    dz_d    = 1'b0;
`ifdef DIV_SAT_EN
                    q_d     = (|quot_next[CW-1:QW]) ? QW'(9'h1FF) : quot_next[QW-1:0];
`else
                    q_d     = quot_next[QW-1:0];
`endif
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.Q    = q_q;
    assign bus.R    = r_q;
    assign bus.ovf  = ovf_q;
    assign bus.dz   = dz_q;

endmodule

// File: tb/tb_seq_divider_16by4.sv
// Directed scoreboard bench for seq_divider_16by4 (latency, busy window, results, abort).
module tb_seq_divider_16by4;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    typedef struct {
        logic [8:0] q;
        logic [3:0] r;
        logic       ovf;
        logic       dz;
    } exp_t;

    exp_t sb[$];

    seq_divider_16by4_if bus ();

    seq_divider_16by4 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input int unsigned c, input int unsigned b);
        exp_t e;
        int unsigned qt;
        if (b == 0) begin
            e.q = 9'h1FF; e.r = 4'h0; e.ovf = 1'b0; e.dz = 1'b1;
        end else begin
            qt    = c / b;
            e.r   = 4'(c % b);
            e.ovf = (qt > 511);
            e.dz  = 1'b0;
`ifdef DIV_SAT_EN
            e.q   = e.ovf ? 9'h1FF : 9'(qt);
`else
            e.q   = 9'(qt);
`endif
        end
        return e;
    endfunction

    // Drive one accepted start; optionally record the expected result
    task automatic start_op(input logic [15:0] c, input logic [3:0] b, input bit push);
        @(negedge clk);
        bus.start = 1'b1;
        bus.C     = c;
        bus.B     = b;
        if (push) sb.push_back(model(int'(c), int'(b)));
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    // Wait for done with a bound; check latency, busy window and the popped result
    task automatic wait_done(input string tag, input int exp_lat, input int exp_busy, input int inj_at);
        int   k  = 0;
        int   nb = 0;
        bit   got = 0;
        exp_t e;
        while (!got && k < 40) begin
            @(negedge clk);
            k++;
            if (k == inj_at) begin
                bus.start = 1'b1; bus.C = 16'd50; bus.B = 4'd3;
            end else if (k == inj_at + 1) begin
                bus.start = 1'b0;
            end
            if (bus.busy) nb++;
            if (bus.busy && bus.done) check({tag, "_busy_done_excl"}, 32'(1), 32'(0));
            if (bus.done) got = 1;
        end
        bus.start = 1'b0;
        check({tag, "_latency"}, got ? 32'(k) : 32'hFFFF_FFFF, 32'(exp_lat));
        check({tag, "_busy_cycles"}, 32'(nb), 32'(exp_busy));
        if (got) begin
            check({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'(1));
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check({tag, "_Q"},   32'(bus.Q),   32'(e.q));
                check({tag, "_R"},   32'(bus.R),   32'(e.r));
                check({tag, "_ovf"}, 32'(bus.ovf), 32'(e.ovf));
                check({tag, "_dz"},  32'(bus.dz),  32'(e.dz));
            end
            @(negedge clk);
            check({tag, "_done_pulse"}, 32'(bus.done), 32'(0));
        end
    endtask

    initial begin
        int nd;
        checks = 0; failures = 0;
        bus.start = 1'b0; bus.C = '0; bus.B = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_busy", 32'(bus.busy), 32'(0));
        check("rst_done", 32'(bus.done), 32'(0));
        check("rst_Q",    32'(bus.Q),    32'(0));
        check("rst_R",    32'(bus.R),    32'(0));
        check("rst_ovf",  32'(bus.ovf),  32'(0));
        check("rst_dz",   32'(bus.dz),   32'(0));

        start_op(16'd4488, 4'd12, 1'b1);  wait_done("d4488_12", 17, 16, -5);
        start_op(16'd1000, 4'd7, 1'b1);   wait_done("d1000_7", 17, 16, -5);
        start_op(16'd511, 4'd1, 1'b1);    wait_done("d511_1", 17, 16, -5);
        start_op(16'hFFFF, 4'd15, 1'b1);  wait_done("dffff_15", 17, 16, -5);
        start_op(16'd1234, 4'd0, 1'b1);   wait_done("dz_1234", 1, 0, -5);
        start_op(16'd9, 4'd15, 1'b1);     wait_done("d9_15", 17, 16, -5);

        // A start pulse mid-calculation must be dropped
        start_op(16'd1000, 4'd7, 1'b1);   wait_done("ignored_start", 17, 16, 6);
        repeat (3) @(negedge clk);
        check("ignored_no_done", 32'(bus.done), 32'(0));
        check("ignored_no_busy", 32'(bus.busy), 32'(0));

        // Reset mid-calculation aborts without a done pulse
        start_op(16'd4488, 4'd12, 1'b0);
        repeat (9) @(negedge clk);
        check("abort_busy_before", 32'(bus.busy), 32'(1));
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_busy", 32'(bus.busy), 32'(0));
        check("abort_done", 32'(bus.done), 32'(0));
        check("abort_Q",    32'(bus.Q),    32'(0));
        check("abort_R",    32'(bus.R),    32'(0));
        check("abort_ovf",  32'(bus.ovf),  32'(0));
        check("abort_dz",   32'(bus.dz),   32'(0));
        nd = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done || bus.busy) nd++;
        end
        check("abort_quiet", 32'(nd), 32'(0));
        start_op(16'd100, 4'd9, 1'b1);    wait_done("d100_9", 17, 16, -5);

        check("sb_drained", 32'(sb.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
